// File: rtl/maple_tx.sv
// maple_tx: Maple bus frame transmitter with start/end patterns, alternating-phase bits and XOR checksum
module maple_tx #(
  parameter int DIV = 36
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       pin1_out,
  output logic       pin5_out,
  output logic       oe,
  output logic       busy,
  output logic       done,
  output logic       underrun
);
  typedef enum logic [2:0] {IDLE, START, DATA, CRC, END, TAIL} state_t;
  state_t state;
  logic [7:0] step_cnt, shift, crc, hold, nxt_byte;
  logic [3:0] idx;
  logic half, phase, hold_valid, last_seen, acc, step_end, bnd, nb;
  assign acc = in_valid & in_ready;
  assign step_end = step_cnt == 8'(DIV - 1);
  assign bnd = state == DATA && step_end && half && idx == 4'd7;
  assign nxt_byte = hold_valid ? hold : acc ? in_data : crc;
  assign nb = idx == 4'd7 ? nxt_byte[7] : shift[6];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step_cnt <= '0;
      idx <= '0;
      half <= 1'b0;
      phase <= 1'b0;
      shift <= '0;
      crc <= '0;
      hold <= '0;
      hold_valid <= 1'b0;
      last_seen <= 1'b0;
      in_ready <= 1'b0;
      pin1_out <= 1'b1;
      pin5_out <= 1'b1;
      oe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      done <= 1'b0;
      step_cnt <= (state == IDLE || step_end) ? 8'd0 : step_cnt + 8'd1;
      if (acc && (state == START || state == DATA)) begin
        crc <= crc ^ in_data;
        last_seen <= in_last;
        in_ready <= 1'b0;
        if (!bnd) begin
          hold <= in_data;
          hold_valid <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          {oe, busy, pin1_out, pin5_out} <= 4'b0011;
          in_ready <= 1'b1;
          if (acc) begin
            state <= START;
            shift <= in_data;
            crc <= in_data;
            last_seen <= in_last;
            hold_valid <= 1'b0;
            underrun <= 1'b0;
            idx <= '0;
            half <= 1'b0;
            phase <= 1'b0;
            {oe, busy, pin1_out, pin5_out} <= 4'b1101;
            in_ready <= ~in_last;
          end
        end
        START: if (step_end) begin
          idx <= idx + 4'd1;
          {pin1_out, pin5_out} <= idx == 4'd8 ? 2'b11 : {1'b0, idx[0]};
          if (idx == 4'd9) begin
            state <= DATA;
            idx <= '0;
            {pin1_out, pin5_out} <= {1'b1, shift[7]};
          end
        end
        DATA, CRC: if (step_end) begin
          half <= ~half;
          if (!half) {pin1_out, pin5_out} <= phase ? {shift[7], 1'b0} : {1'b0, shift[7]};
          else begin
            phase <= ~phase;
            idx <= idx + 4'd1;
            shift <= {shift[6:0], 1'b0};
            {pin1_out, pin5_out} <= phase ? {1'b1, nb} : {nb, 1'b1};
            if (idx == 4'd7) begin
              idx <= '0;
              shift <= nxt_byte;
              if (state == CRC) begin
                state <= END;
                {pin1_out, pin5_out} <= 2'b10;
              end else if (hold_valid) begin
                hold_valid <= 1'b0;
                in_ready <= ~last_seen;
              end else if (acc) in_ready <= ~in_last;
              else begin
                state <= CRC;
                underrun <= ~last_seen;
                in_ready <= 1'b0;
              end
            end
          end
        end
        END: if (step_end) begin
          idx <= idx + 4'd1;
          {pin1_out, pin5_out} <= idx == 4'd4 ? 2'b11 : {idx[0], 1'b0};
          if (idx == 4'd5) begin
            state <= TAIL;
            {pin1_out, pin5_out} <= 2'b11;
          end
        end
        TAIL: begin
          if (step_cnt == 8'(DIV - 2)) done <= 1'b1;
          if (step_end) begin
            state <= IDLE;
            {oe, busy} <= 2'b00;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maple_tx.sv
// tb_maple_tx: scoreboard bench for maple_tx at DIV=4 and DIV=2 with a pin-level receiver model
module tb_maple_tx;
  logic clk = 1'b0, reset = 1'b1, sel = 1'b0;
  logic [7:0] in_data [2];
  logic in_valid [2], in_last [2], in_ready [2], p1 [2], p5 [2], oe [2], busy [2], done [2], und [2];
  logic o_rdy, o_p1, o_p5, o_oe, o_busy, o_done, o_und;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  logic [7:0] q [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  maple_tx #(.DIV(4)) u4 (.clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .pin1_out(p1[0]), .pin5_out(p5[0]), .oe(oe[0]),
    .busy(busy[0]), .done(done[0]), .underrun(und[0]));
  maple_tx #(.DIV(2)) u2 (.clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .pin1_out(p1[1]), .pin5_out(p5[1]), .oe(oe[1]),
    .busy(busy[1]), .done(done[1]), .underrun(und[1]));
  assign o_rdy = in_ready[sel];
  assign o_p1 = p1[sel];
  assign o_p5 = p5[sel];
  assign o_oe = oe[sel];
  assign o_busy = busy[sel];
  assign o_done = done[sel];
  assign o_und = und[sel];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  logic pv_oe = 1'b0, pv_p1 = 1'b1, pv_p5 = 1'b1, exp_a = 1'b1;
  logic [7:0] sh = '0;
  int nb = 0, rise_cyc = 0, fall_cyc = 0, done_cnt = 0, frame_len = 0, run = 0;
  always @(negedge clk) begin
    if (o_oe && !pv_oe) begin
      rise_cyc = cyc;
      fall_cyc = 0;
      done_cnt = 0;
      exp_a = 1'b1;
      nb = 0;
      run = 0;
    end
    if (o_oe) run++;
    if (!o_oe && pv_oe) frame_len = run;
    if (o_done) done_cnt++;
    if (o_oe && pv_oe) begin
      if (fall_cyc == 0 && pv_p1 && !o_p1) fall_cyc = cyc;
      if (q.size() > 0 && (exp_a ? (pv_p1 && !o_p1) : (pv_p5 && !o_p5))) begin
        sh = {sh[6:0], exp_a ? o_p5 : o_p1};
        exp_a = ~exp_a;
        nb++;
        if (nb == 8) begin
          check("rx_byte", 32'(sh), 32'(q.pop_front()));
          nb = 0;
        end
      end
    end
    pv_oe = o_oe;
    pv_p1 = o_p1;
    pv_p5 = o_p5;
  end
  task automatic send(input logic [7:0] d, input logic l, output int acc_cyc);
    in_data[sel] = d;
    in_last[sel] = l;
    in_valid[sel] = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 2000 && acc_cyc < 0; i++) begin
      if (o_rdy) begin
        acc_cyc = cyc;
        q.push_back(d);
      end
      @(negedge clk);
    end
    in_valid[sel] = 1'b0;
    check("accepted", 32'(acc_cyc >= 0), 1);
  endtask
  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !o_done; i++) @(negedge clk);
    check("done_seen", 32'(o_done), 1);
  endtask
  task automatic wait_cyc(input int c);
    for (int i = 0; i < 5000 && cyc < c; i++) @(negedge clk);
  endtask
  initial begin
    int t, d, k, extra;
    logic [7:0] bp [3];
    bp = '{8'h11, 8'h22, 8'h44};
    for (int i = 0; i < 2; i++) begin
      in_data[i] = '0;
      in_valid[i] = 1'b0;
      in_last[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({o_oe, o_p1, o_p5, o_rdy, o_busy, o_done, o_und}), 32'h30);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(o_rdy), 1);
    send(8'hA5, 1'b1, t);
    q.push_back(8'hA5);
    check("start_latency", 32'({o_oe, o_p1, o_p5, o_busy}), 32'hB);
    wait_done(400);
    check("single_done_time", 32'(cyc - t), 196);
    @(negedge clk);
    check("single_idle_after", 32'({o_oe, o_busy, o_rdy, o_p1, o_p5}), 32'h7);
    @(negedge clk);
    check("single_frame_len", 32'(frame_len), 196);
    check("single_bit0_fall", 32'(fall_cyc - rise_cyc), 44);
    check("single_done_pulses", 32'(done_cnt), 1);
    check("single_underrun", 32'(o_und), 0);
    check("single_queue_empty", 32'(q.size()), 0);
    sel = 1'b1;
    @(negedge clk);
    send(8'h01, 1'b0, t);
    send(8'h02, 1'b0, d);
    send(8'h04, 1'b0, d);
    send(8'h08, 1'b1, d);
    q.push_back(8'h0F);
    wait_done(500);
    repeat (2) @(negedge clk);
    check("four_frame_len", 32'(frame_len), 194);
    check("four_queue_empty", 32'(q.size()), 0);
    check("four_underrun", 32'(o_und), 0);
    send(8'h3C, 1'b0, t);
    q.push_back(8'h3C);
    wait_cyc(t + 52);
    check("underrun_before_bnd", 32'(o_und), 0);
    @(negedge clk);
    check("underrun_at_bnd", 32'(o_und), 1);
    wait_done(300);
    in_data[sel] = 8'h77;
    in_last[sel] = 1'b1;
    in_valid[sel] = 1'b1;
    @(negedge clk);
    check("b2b_gap", 32'({o_rdy, o_oe}), 32'h2);
    check("underrun_queue_empty", 32'(q.size()), 0);
    q.push_back(8'h77);
    q.push_back(8'h77);
    @(negedge clk);
    in_valid[sel] = 1'b0;
    check("b2b_restart", 32'({o_oe, o_busy, o_und}), 32'h6);
    check("underrun_frame_len", 32'(frame_len), 98);
    wait_done(300);
    repeat (2) @(negedge clk);
    check("b2b_frame_len", 32'(frame_len), 98);
    check("b2b_done_pulses", 32'(done_cnt), 1);
    check("b2b_queue_empty", 32'(q.size()), 0);
    send(8'hC3, 1'b0, t);
    wait_cyc(t + 52);
    in_data[sel] = 8'h3C;
    in_last[sel] = 1'b1;
    in_valid[sel] = 1'b1;
    check("bypass_ready", 32'(o_rdy), 1);
    q.push_back(8'h3C);
    q.push_back(8'hFF);
    @(negedge clk);
    in_valid[sel] = 1'b0;
    wait_done(400);
    repeat (2) @(negedge clk);
    check("bypass_underrun", 32'(o_und), 0);
    check("bypass_frame_len", 32'(frame_len), 130);
    check("bypass_queue_empty", 32'(q.size()), 0);
    k = 0;
    extra = 0;
    in_valid[sel] = 1'b1;
    for (int i = 0; i < 1000 && !o_done; i++) begin
      in_data[sel] = k < 3 ? bp[k] : 8'h99;
      in_last[sel] = k == 2;
      if (o_rdy) begin
        if (k < 3) begin
          q.push_back(bp[k]);
          if (k == 2) q.push_back(8'h77);
          k++;
        end else extra++;
      end
      @(negedge clk);
    end
    in_valid[sel] = 1'b0;
    check("bp_done", 32'(o_done), 1);
    check("bp_accepts", 32'(k), 3);
    check("bp_extra_accepts", 32'(extra), 0);
    @(negedge clk);
    check("bp_ready_returns", 32'(o_rdy), 1);
    @(negedge clk);
    check("bp_frame_len", 32'(frame_len), 162);
    check("bp_queue_empty", 32'(q.size()), 0);
    send(8'h5A, 1'b1, t);
    wait_cyc(t + 61);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_frame", 32'({o_oe, o_p1, o_p5, o_busy, o_rdy}), 32'hC);
    reset = 1'b0;
    @(negedge clk);
    check("reset_release_ready", 32'({o_rdy, o_oe}), 32'h2);
    check("reset_queue_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/maple_tx.md
# maple_tx

Maple bus frame transmitter in the `hdmi_clock` domain. It is the transmit counterpart of the `maple` receiver: it takes a byte stream with a valid/ready handshake and serializes it onto the two Maple lines (pin1/SDCKA, pin5/SDCKB). It adds the start pattern, alternating-phase data bits, an XOR checksum byte and the end pattern. The top level drives the pins through tristate buffers gated by `oe`. `busy` lets the receiver ignore the block's own traffic.

## Interface
- `DIV`, default 36: clocks per step; legal range 2..255.
- `clk`  in  1  `hdmi_clock`; the block's only clock.
- `reset`  in  1  reset, synchronous and active-high.
- `in_data`  in  8  payload byte, sent MSB first.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  marks the final payload byte of a frame; qualified by `in_valid`.
- `in_ready`  out  1  byte is accepted on a cycle where `in_valid & in_ready`.
- `pin1_out`  out  1  SDCKA drive value.
- `pin5_out`  out  1  SDCKB drive value.
- `oe`  out  1  pin drive enable.
- `busy`  out  1  high from first-byte accept until the `done` cycle, inclusive.
- `done`  out  1  one-cycle pulse at frame end.
- `underrun`  out  1  sticky flag; cleared by `reset` or by the next frame's first accept.

## Operation
- **Step timing:** a step lasts `DIV` clocks, counted by `step_cnt` 0..DIV-1. Pin values change only at step boundaries.
- **States:** IDLE, START, DATA, CRC, END, TAIL.
- **IDLE**
  - Outputs: `oe`=0, pins=1, `in_ready`=1.
  - On accept: byte goes to `shift`, `crc` is set to the byte, `last_seen` is set to `in_last`, then go to START.
- **START** (10 steps)
  - Step 1: pin1=0, pin5=1.
  - Steps 2–9: pin1=0 with pin5 = 0,1,0,1,0,1,0,1.
  - Step 10: both pins 1.
- **DATA** (2 steps per bit)
  - A global bit counter alternates the phase across the whole frame. Frame bit 0 is phase A.
  - Phase A: step 1 pin5=bit, pin1=1; step 2 pin5=bit, pin1=0.
  - Phase B: the same with pin1 and pin5 swapped.
- **Hold register (one byte)**
  - `in_ready` = `~hold_valid & ~last_seen` while in START or DATA.
  - Each accept sets `hold_valid`, XORs the byte into `crc` and updates `last_seen`.
- **Byte boundary** (after bit 7's second step)
  - `hold_valid`: load `shift` from the hold register, clear `hold_valid`.
  - `~hold_valid & last_seen`: load `crc` into `shift`, go to CRC.
  - `~hold_valid & ~last_seen`: set `underrun`, load `crc`, go to CRC. The frame closes normally; later bytes wait for IDLE.
- **CRC:** 8 bits, same bit encoding and continuing phase, then go to END.
- **END** (6 steps)
  - Step 1: pin1=1, pin5=0.
  - Steps 2–5: pin5=0 with pin1 = 0,1,0,1.
  - Step 6: both pins 1.
- **TAIL** (1 step): `oe`=1, pins=1. On the last clock, `done`=1 and the next state is IDLE.
- **Reset values:** `oe`=0, `pin1_out`=1, `pin5_out`=1, `in_ready`=0, `busy`=0, `done`=0, `underrun`=0, state IDLE.
- **Reset mid-frame:** lines are released on the following cycle. No end pattern is sent.

## Timing
- All outputs are registered.
- **Start latency:** accept at cycle t gives `oe`=1, `pin1_out`=0, `busy`=1 at t+1.
- **Frame length:** (10 + 16·(N+1) + 6 + 1)·DIV clocks for N payload bytes. `done` is high in the last of these cycles. `busy` falls together with `oe` on the next cycle.
- **Next frame:** `in_ready` returns to 1 the cycle after `done`. Minimum inter-frame gap is 1 clock.
- **Boundary conditions:**
  - `in_valid` held while `last_seen`=1: `in_ready` stays 0 and nothing is consumed.
  - An accept in the same cycle as the byte boundary counts as "hold available" (bypass), so there is no underrun.
- **Checksum width:** XOR is 8 bits wide. No carry; no wrap issues.

## Test plan
- **Single byte:** DIV=4, one byte 0xA5 with `in_last`. Required: 49 steps = 196 clocks. Checksum byte is 0xA5. The bit-0 pin1 fall lands 44 clocks after accept. `done` is a single pulse; `underrun`=0.
- **Four-byte frame:** bytes 0x01,0x02,0x04,0x08, last on 0x08, DIV=2. Required: checksum 0x0F. The receiver model (sample pin5 on pin1 fall, pin1 on pin5 fall) decodes exactly 01 02 04 08 0F. Frame is 97 steps.
- **Underrun:** first byte 0x3C without last, `in_valid` low afterwards. Required: checksum 0x3C follows immediately. `underrun`=1 at the byte-0 boundary, normal END/TAIL, `done` asserted.
- **Back-to-back frames:** a second frame is offered on the cycle after `done`. Required: accepted there, `oe` low for exactly 1 clock, `underrun` cleared.
- **Reset mid-frame:** `reset` pulsed during CRC. Required: the next cycle shows `oe`=0, pins=1, `busy`=0, `in_ready`=0; `in_ready`=1 the cycle after `reset` falls.
- **Backpressure:** `in_valid` held high through a 3-byte frame. Required: `in_ready` low after last accept; no byte is consumed until IDLE.
